uart_tx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_fifo_mem.sv | 37 +++
 rtl/uart_tx_fifo.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit path
//
// Purpose: FSM state encoding for uart_tx_fifo, the byte type used on all
// byte-wide paths, and the default FIFO depth.
// Ports: none (package).
// Build option: none here; uart_tx_fifo honours UART_TX_FIFO_OVF_EN.

package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_fifo_state_t;

  typedef logic [7:0] uart_byte_t;

  localparam int UART_TX_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// rtl/uart_tx_fifo_mem.sv - DEPTH x 8 storage array for the UART transmit FIFO
//
// Purpose: byte storage with a synchronous write port and a combinational
// read port. Contents are not reset; validity is tracked by the parent's count.
// Ports:
//   clk        in  : clock, rising edge
//   wr_en_i    in  : write strobe
//   wr_addr_i  in  : write address (ADDR_W bits)
//   wr_data_i  in  : write byte
//   rd_addr_i  in  : read address (ADDR_W bits)
//   rd_data_o  out : byte stored at rd_addr_i

module uart_tx_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_TX_FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  uart_byte_t        wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output uart_byte_t        rd_data_o
);

  uart_byte_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO that paces launches into a UART on tx_busy
//
// Purpose: buffers host bytes in a circular FIFO and hands them to the UART
// one at a time through its din/wr_en load interface, waiting for each
// frame to start and finish before launching the next.
// Ports:
//   clk           in  : clock, rising edge
//   reset         in  : asynchronous active-high reset, clears all state
//   host_din      in  : byte to enqueue
//   host_wr       in  : enqueue strobe
//   full          out : FIFO holds DEPTH bytes
//   empty         out : FIFO holds no bytes
//   count         out : bytes currently stored (ADDR_W+1 bits)
//   uart_din      out : byte presented to UART din
//   uart_wr_en    out : one-cycle load pulse to UART wr_en
//   uart_tx_busy  in  : UART tx_busy
//   overflow      out : sticky dropped-push flag (only with UART_TX_FIFO_OVF_EN)
// Build option: define UART_TX_FIFO_OVF_EN to add the overflow output.

module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH        = UART_TX_FIFO_DEPTH,
  parameter int ADDR_W       = $clog2(DEPTH),
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  uart_byte_t      host_din,
  input  logic            host_wr,
  output logic            full,
  output logic            empty,
  output logic [ADDR_W:0] count,
  output uart_byte_t      uart_din,
  output logic            uart_wr_en,
  input  logic            uart_tx_busy
`ifdef UART_TX_FIFO_OVF_EN
  ,
  output logic            overflow
`endif
);

  localparam int                TMO_W      = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(BUSY_TIMEOUT - 1);
  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q,  count_d;
  tx_fifo_state_t    state_q;
  uart_byte_t        din_q;
  logic              wr_en_q;
  logic [TMO_W-1:0]  tmo_q;
  uart_byte_t        head_byte;
  logic              push;
  logic              pop;

  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);
  assign count = count_q;

  // A push while full is dropped even if a pop frees a slot this cycle,
  // because full is decoded from the registered count.
  assign push = host_wr && !full;
  assign pop  = (state_q == IDLE) && !empty && !uart_tx_busy;

  uart_tx_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (push),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (host_din),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (head_byte)
  );

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Launch sequencer. uart_wr_en is registered so it is high exactly for
  // the cycle the FSM sits in LAUNCH. If the UART never raises busy, the
  // byte is considered sent after BUSY_TIMEOUT cycles in WAIT_BUSY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      din_q   <= '0;
      wr_en_q <= 1'b0;
      tmo_q   <= '0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q <= LAUNCH;
            din_q   <= head_byte;
            wr_en_q <= 1'b1;
          end
        end
        LAUNCH: begin
          state_q <= WAIT_BUSY;
          tmo_q   <= '0;
        end
        WAIT_BUSY: begin
          if (uart_tx_busy) begin
            state_q <= WAIT_DONE;
          end else if (tmo_q == TMO_LAST) begin
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!uart_tx_busy) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign uart_din   = din_q;
  assign uart_wr_en = wr_en_q;

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (host_wr && full) begin
      ovf_q <= 1'b1;
    end
  end

  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo with a UART busy model

module tb_uart_tx_fifo;

  localparam int DEPTH        = 16;
  localparam int ADDR_W       = 4;
  localparam int BUSY_TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        host_din;
  logic              host_wr;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic [7:0]        uart_din;
  logic              uart_wr_en;
  logic              uart_tx_busy;
  logic              hold_busy = 1'b0;
  logic              model_busy = 1'b0;
`ifdef UART_TX_FIFO_OVF_EN
  logic              overflow;
`endif

  int checks = 0;
  int errors = 0;

  // UART behavioural model configuration and state
  bit  never_busy = 1'b0;
  int  busy_delay = 2;
  int  frame_len  = 10;
  int  rise_in    = 0;
  int  busy_left  = 0;
  int  ncyc       = 0;
  int  viol       = 0;
  logic [7:0] launches[$];
  int         launch_cyc[$];
  logic [7:0] exp_q[$];

  assign uart_tx_busy = hold_busy | model_busy;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DEPTH        (DEPTH),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .host_din     (host_din),
    .host_wr      (host_wr),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .uart_din     (uart_din),
    .uart_wr_en   (uart_wr_en),
    .uart_tx_busy (uart_tx_busy)
`ifdef UART_TX_FIFO_OVF_EN
    ,
    .overflow     (overflow)
`endif
  );

  // UART model: captures each load, raises busy busy_delay cycles later
  // and holds it for frame_len cycles.
  always @(negedge clk) begin
    ncyc++;
    if (uart_wr_en) begin
      if (uart_tx_busy) viol++;
      launches.push_back(uart_din);
      launch_cyc.push_back(ncyc);
      if (!never_busy) rise_in = busy_delay;
    end else if (rise_in > 0) begin
      rise_in--;
      if (rise_in == 0) begin
        model_busy = 1'b1;
        busy_left  = frame_len;
      end
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) model_busy = 1'b0;
    end
  end

  task automatic push_byte(input logic [7:0] b);
    host_din = b;
    host_wr  = 1'b1;
    @(negedge clk);
    host_wr  = 1'b0;
  endtask

  task automatic wait_launches(input int n, input int budget);
    int k = 0;
    while (launches.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    #1;
  endtask

  task automatic clear_log();
    launches.delete();
    launch_cyc.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; host_wr = 1'b0; host_din = 8'h00; hold_busy = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (uart_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", uart_wr_en); end
    checks++; if (uart_din !== 8'h00) begin errors++; $display("FAIL reset_din: got %h expected 00", uart_din); end
`ifdef UART_TX_FIFO_OVF_EN
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
`endif
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (launches.size() != 0) begin errors++; $display("FAIL reset_no_launch: got %0d launches expected 0", launches.size()); end
  endtask

  task automatic test_single();
    never_busy = 1'b0; busy_delay = 2; frame_len = 100;
    clear_log();
    push_byte(8'hA5);
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", count); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty: got %b expected 0", empty); end
    checks++; if (uart_wr_en !== 1'b0) begin errors++; $display("FAIL single_early_wr_en: got %b expected 0", uart_wr_en); end
    @(negedge clk);
    checks++; if (uart_wr_en !== 1'b1) begin errors++; $display("FAIL single_wr_en: got %b expected 1", uart_wr_en); end
    checks++; if (uart_din !== 8'hA5) begin errors++; $display("FAIL single_din: got %h expected a5", uart_din); end
    repeat (110) @(negedge clk);
    #1;
    checks++; if (launches.size() != 1) begin errors++; $display("FAIL single_pulses: got %0d expected 1", launches.size()); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_after: got %b expected 1", empty); end
  endtask

  task automatic test_fill_overflow();
    hold_busy = 1'b1; busy_delay = 1; frame_len = 3;
    @(negedge clk);
    clear_log();
    for (int i = 1; i <= DEPTH + 1; i++) begin
      logic [7:0] b;
      b = (i == DEPTH + 1) ? 8'hFF : 8'(i);
      push_byte(b);
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      if (i == DEPTH) begin
        checks++; if (count !== 5'(DEPTH)) begin errors++; $display("FAIL fill_count: got %0d expected %0d", count, DEPTH); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b expected 1", full); end
      end
    end
    checks++; if (count !== 5'(DEPTH)) begin errors++; $display("FAIL drop_count: got %0d expected %0d", count, DEPTH); end
`ifdef UART_TX_FIFO_OVF_EN
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL drop_overflow: got %b expected 1", overflow); end
`endif
    hold_busy = 1'b0;
    wait_launches(DEPTH, DEPTH * 30);
    repeat (20) @(negedge clk);
    #1;
    checks++; if (launches.size() != exp_q.size()) begin errors++; $display("FAIL fill_launch_count: got %0d expected %0d", launches.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < launches.size(); i++) begin
      checks++; if (launches[i] !== exp_q[i]) begin errors++; $display("FAIL fill_order[%0d]: got %h expected %h", i, launches[i], exp_q[i]); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fill_drained: got %b expected 1", empty); end
  endtask

  task automatic test_push_pop();
    hold_busy = 1'b1; busy_delay = 1; frame_len = 3;
    @(negedge clk);
    clear_log();
    for (int i = 0; i < DEPTH - 1; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      push_byte(b);
      exp_q.push_back(b);
    end
    checks++; if (count !== 5'(DEPTH - 1)) begin errors++; $display("FAIL pp_pre_count: got %0d expected %0d", count, DEPTH - 1); end
    host_din = 8'h3C; host_wr = 1'b1; hold_busy = 1'b0;
    @(negedge clk);
    host_wr = 1'b0;
    exp_q.push_back(8'h3C);
    checks++; if (count !== 5'(DEPTH - 1)) begin errors++; $display("FAIL pp_count: got %0d expected %0d", count, DEPTH - 1); end
    checks++; if (uart_wr_en !== 1'b1 || uart_din !== exp_q[0]) begin errors++; $display("FAIL pp_launch: got wr_en %b din %h expected 1 %h", uart_wr_en, uart_din, exp_q[0]); end
    wait_launches(DEPTH, DEPTH * 30);
    checks++; if (launches.size() != DEPTH) begin errors++; $display("FAIL pp_launch_count: got %0d expected %0d", launches.size(), DEPTH); end
    for (int i = 0; i < DEPTH && i < launches.size(); i++) begin
      checks++; if (launches[i] !== exp_q[i]) begin errors++; $display("FAIL pp_order[%0d]: got %h expected %h", i, launches[i], exp_q[i]); end
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_no_busy();
    never_busy = 1'b1;
    @(negedge clk);
    clear_log();
    push_byte(8'h5A);
    push_byte(8'hC3);
    wait_launches(2, 60);
    checks++; if (launches.size() != 2) begin errors++; $display("FAIL nb_count: got %0d expected 2", launches.size()); end
    if (launches.size() == 2) begin
      // LAUNCH cycle + BUSY_TIMEOUT cycles waiting + one IDLE cycle
      checks++; if (launch_cyc[1] - launch_cyc[0] != 2 + BUSY_TIMEOUT) begin errors++; $display("FAIL nb_spacing: got %0d expected %0d", launch_cyc[1] - launch_cyc[0], 2 + BUSY_TIMEOUT); end
      checks++; if (launches[0] !== 8'h5A || launches[1] !== 8'hC3) begin errors++; $display("FAIL nb_order: got %h %h expected 5a c3", launches[0], launches[1]); end
    end
    repeat (10) @(negedge clk);
    never_busy = 1'b0;
  endtask

  task automatic test_reset_mid();
    busy_delay = 2; frame_len = 60;
    @(negedge clk);
    clear_log();
    for (int i = 0; i < 6; i++) push_byte(8'h90 + 8'(i));
    repeat (8) @(negedge clk);
    #1;
    checks++; if (count !== 5'(6 - launches.size()) || launches.size() != 1) begin errors++; $display("FAIL rm_pre_count: got %0d expected 5", count); end
`ifdef UART_TX_FIFO_OVF_EN
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL rm_overflow_sticky: got %b expected 1", overflow); end
`endif
    reset = 1'b1;
    #1;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL rm_count: got %0d expected 0", count); end
    checks++; if (uart_wr_en !== 1'b0 || uart_din !== 8'h00) begin errors++; $display("FAIL rm_outputs: got wr_en %b din %h expected 0 00", uart_wr_en, uart_din); end
`ifdef UART_TX_FIFO_OVF_EN
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rm_overflow_clear: got %b expected 0", overflow); end
`endif
    @(negedge clk);
    reset = 1'b0;
    repeat (80) @(negedge clk);
    #1;
    checks++; if (launches.size() != 1) begin errors++; $display("FAIL rm_no_launch: got %0d launches expected 1", launches.size()); end
    push_byte(8'h77);
    wait_launches(2, 20);
    checks++; if (launches.size() != 2 || launches[launches.size()-1] !== 8'h77) begin errors++; $display("FAIL rm_relaunch: got %0d launches expected 2 ending 77", launches.size()); end
    repeat (80) @(negedge clk);
  endtask

  task automatic test_random();
    int guard;
    clear_log();
    viol = 0;
    for (int i = 0; i < 200; i++) begin
      logic [7:0] b;
      busy_delay = $urandom_range(1, 3);
      frame_len  = $urandom_range(2, 12);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      guard = 0;
      while (full && guard < 1000) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 1000) begin
        checks++; errors++;
        $display("FAIL rand_full_stuck: got full=1 for %0d cycles expected drain", guard);
      end
      b = 8'($urandom);
      push_byte(b);
      exp_q.push_back(b);
    end
    wait_launches(200, 20000);
    checks++; if (launches.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", launches.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < launches.size(); i++) begin
      checks++; if (launches[i] !== exp_q[i]) begin errors++; $display("FAIL rand_order[%0d]: got %h expected %h", i, launches[i], exp_q[i]); end
    end
    checks++; if (viol != 0) begin errors++; $display("FAIL rand_wr_en_while_busy: got %0d expected 0", viol); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_push_pop();
    test_no_busy();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
